// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between the I-cache refill path and
// the D-cache read/write path. One outstanding transaction at a time, round-robin
// grant under contention, registered request fields, combinational response
// pass-through and a wait-cycle watchdog that releases the port on a missing ack.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_read_req, i_addr            I-side read request (level) and address
//   i_ok, i_data                  I-side completion pulse and read data
//   d_read_req, d_write_req       D-side read / write requests (level)
//   d_addr, d_wdata               D-side address and write data
//   d_ok, d_rdata                 D-side completion pulse and read data
//   mem_req, mem_we               memory request and write enable
//   mem_addr, mem_wdata           memory address and write data
//   mem_ack, mem_rdata            memory completion and read data
//   busy                          arbiter owns a transaction
//   timeout_err                   one-cycle pulse after a watchdog abort
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_read_req,
   input  logic [31:0] i_addr,
   output logic        i_ok,
   output logic [31:0] i_data,
   input  logic        d_read_req,
   input  logic        d_write_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ok,
   output logic [31:0] d_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        timeout_err
);

   typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

   localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic        last_d_q, last_d_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        timeout_q, timeout_d;

   logic d_req;
   logic grant_i, grant_d;

   assign d_req = d_read_req | d_write_req;

   always_comb begin
      state_d    = state_q;
      last_d_d   = last_d_q;
      wait_cnt_d = wait_cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      timeout_d  = 1'b0;
      grant_i    = 1'b0;
      grant_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (i_read_req && d_req) begin
               // Contention: serve the side that was not served last.
               grant_d = !last_d_q;
               grant_i = last_d_q;
            end else begin
               grant_i = i_read_req;
               grant_d = d_req;
            end

            if (grant_i) begin
               state_d    = StBusyI;
               addr_d     = i_addr;
               wdata_d    = '0;
               we_d       = 1'b0;
               wait_cnt_d = '0;
            end else if (grant_d) begin
               state_d    = StBusyD;
               addr_d     = d_addr;
               wdata_d    = d_wdata;
               we_d       = d_write_req;  // write wins when both D requests are high
               wait_cnt_d = '0;
            end
         end

         StBusyI, StBusyD: begin
            if (mem_ack) begin
               state_d  = StIdle;
               last_d_d = (state_q == StBusyD);
            end else if (wait_cnt_q == WaitLast) begin
               // Abort: requester still holds its request and re-arbitrates.
               state_d   = StIdle;
               last_d_d  = (state_q == StBusyD);
               timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         last_d_q   <= 1'b0;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_d_q   <= last_d_d;
         wait_cnt_q <= wait_cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         timeout_q  <= timeout_d;
      end
   end

   // Request fields are gated so every memory-side output reads 0 while idle.
   assign busy        = (state_q != StIdle);
   assign mem_req     = busy;
   assign mem_we      = busy & we_q;
   assign mem_addr    = busy ? addr_q : '0;
   assign mem_wdata   = busy ? wdata_q : '0;
   assign i_ok        = (state_q == StBusyI) & mem_ack;
   assign d_ok        = (state_q == StBusyD) & mem_ack;
   assign i_data      = i_ok ? mem_rdata : '0;
   assign d_rdata     = d_ok ? mem_rdata : '0;
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the sequencer pushes expected memory requests
// and responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_read_req, d_read_req, d_write_req;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic        i_ok, d_ok, mem_req, mem_we, mem_ack, busy, timeout_err;
   logic [31:0] i_data, d_rdata, mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .i_read_req(i_read_req), .i_addr(i_addr), .i_ok(i_ok), .i_data(i_data),
      .d_read_req(d_read_req), .d_write_req(d_write_req), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ok(d_ok), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .timeout_err(timeout_err)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          len;   // cycles mem_req stays high
      int          gap;   // idle cycles before the rise, -1 = don't care
   } req_t;

   typedef struct {
      int          kind;  // 0 = i_ok, 1 = d_ok, 2 = timeout_err
      logic [31:0] data;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // Memory model controls (written by the sequencer only).
   logic        mem_auto   = 1'b0;
   int          ack_delay  = 1;
   logic        use_fixed  = 1'b0;
   logic [31:0] fixed_data = '0;
   logic        force_ack  = 1'b0;

   // Values sampled at the last negedge by cycle().
   logic s_req, s_we, s_busy, s_i_ok, s_d_ok, s_to, s_zero;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got event expected none", name);
   endtask

   task automatic exp_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int len, input int gap);
      req_t r;
      r.we = we; r.addr = addr; r.wdata = wdata; r.len = len; r.gap = gap;
      req_q.push_back(r);
   endtask

   task automatic exp_rsp(input int kind, input logic [31:0] data);
      rsp_t r;
      r.kind = kind; r.data = data;
      rsp_q.push_back(r);
   endtask

   // One clock cycle: sample at negedge, then act as the requesters would and drop
   // a request in the cycle after its ok.
   task automatic cycle();
      @(negedge clk);
      s_req  = mem_req;
      s_we   = mem_we;
      s_busy = busy;
      s_i_ok = i_ok;
      s_d_ok = d_ok;
      s_to   = timeout_err;
      s_zero = !(mem_req || mem_we || (|mem_addr) || (|mem_wdata) || i_ok || d_ok ||
                 (|i_data) || (|d_rdata) || busy || timeout_err);
      @(posedge clk);
      #1;
      if (s_i_ok) i_read_req = 1'b0;
      if (s_d_ok) begin
         d_read_req  = 1'b0;
         d_write_req = 1'b0;
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((i_read_req || d_read_req || d_write_req || s_busy) && n < 200) begin
         cycle();
         n++;
      end
      chk(name, 32'(n < 200), 32'd1);
   endtask

   // Memory responder: acks the ack_delay-th busy cycle, or on force_ack regardless.
   initial begin
      int cnt;
      cnt = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         mem_ack = 1'b0;
         mem_rdata = '0;
         if (force_ack) begin
            mem_ack = 1'b1;
            mem_rdata = 32'hCAFEF00D;
            cnt = 0;
         end else if (mem_req && mem_auto) begin
            cnt++;
            if (cnt == ack_delay) begin
               mem_ack = 1'b1;
               mem_rdata = use_fixed ? fixed_data : ~mem_addr;
               cnt = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor.
   logic mon_active = 1'b0;
   logic mon_have   = 1'b0;
   int   mon_len    = 0;
   int   mon_gap    = 1000;
   req_t mon_cur;

   always @(negedge clk) begin
      int   n_ok, got_kind;
      logic [31:0] got_data;
      rsp_t e;
      if (mem_req) begin
         if (!mon_active) begin
            mon_active = 1'b1;
            mon_len = 0;
            if (req_q.size() == 0) begin
               fail_now("mem_req_unexpected");
               mon_have = 1'b0;
            end else begin
               mon_cur = req_q.pop_front();
               mon_have = 1'b1;
               if (mon_cur.gap >= 0) chk("mem_req_gap", 32'(mon_gap), 32'(mon_cur.gap));
            end
         end
         mon_len++;
         if (mon_have) begin
            chk("mem_we", {31'b0, mem_we}, {31'b0, mon_cur.we});
            chk("mem_addr", mem_addr, mon_cur.addr);
            chk("mem_wdata", mem_wdata, mon_cur.wdata);
         end
      end else begin
         if (mon_active) begin
            if (mon_have) chk("mem_req_len", 32'(mon_len), 32'(mon_cur.len));
            mon_active = 1'b0;
            mon_have = 1'b0;
            mon_gap = 0;
         end
         mon_gap++;
         chk("idle_mem_zero", {31'b0, mem_we || (|mem_addr) || (|mem_wdata)}, 32'd0);
      end
      chk("busy_eq_req", {31'b0, busy}, {31'b0, mem_req});
      chk("ok_data_zero", {31'b0, (!i_ok && i_data != 0) || (!d_ok && d_rdata != 0)}, 32'd0);

      n_ok = 0;
      if (i_ok) n_ok++;
      if (d_ok) n_ok++;
      if (timeout_err) n_ok++;
      if (n_ok > 1) fail_now("ok_overlap");
      if (n_ok != 0) begin
         got_kind = i_ok ? 0 : (d_ok ? 1 : 2);
         got_data = i_ok ? i_data : (d_ok ? d_rdata : 32'd0);
         if (rsp_q.size() == 0) begin
            fail_now("rsp_unexpected");
         end else begin
            e = rsp_q.pop_front();
            chk("rsp_kind", 32'(got_kind), 32'(e.kind));
            chk("rsp_data", got_data, e.data);
         end
      end
   end

   // Sequencer.
   initial begin
      rst = 1'b1;
      i_read_req = 1'b0; d_read_req = 1'b0; d_write_req = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      @(posedge clk);
      #1;
      cycle();
      chk("reset_zero", {31'b0, s_zero}, 32'd1);
      rst = 1'b0;
      cycle();
      chk("idle_zero", {31'b0, s_zero}, 32'd1);

      // Contention from reset: D, I, then D, I again.
      mem_auto = 1'b1; ack_delay = 2;
      d_addr = 32'h0000_3000; i_addr = 32'h0040_0100;
      exp_req(1'b0, 32'h0000_3000, 32'h0, 2, -1); exp_rsp(1, 32'hFFFF_CFFF);
      exp_req(1'b0, 32'h0040_0100, 32'h0, 2, 1);  exp_rsp(0, 32'hFFBF_FEFF);
      i_read_req = 1'b1; d_read_req = 1'b1;
      wait_done("contend1_done");
      d_addr = 32'h0000_3004; i_addr = 32'h0040_0104;
      exp_req(1'b0, 32'h0000_3004, 32'h0, 2, -1); exp_rsp(1, 32'hFFFF_CFFB);
      exp_req(1'b0, 32'h0040_0104, 32'h0, 2, 1);  exp_rsp(0, 32'hFFBF_FEFB);
      i_read_req = 1'b1; d_read_req = 1'b1;
      wait_done("contend2_done");

      // Single I read, ack on the 4th busy cycle.
      use_fixed = 1'b1; fixed_data = 32'hDEAD_BEEF; ack_delay = 4;
      i_addr = 32'h0040_0010;
      exp_req(1'b0, 32'h0040_0010, 32'h0, 4, -1); exp_rsp(0, 32'hDEAD_BEEF);
      i_read_req = 1'b1;
      cycle();
      chk("i_req_lat0", {31'b0, s_req}, 32'd0);
      cycle();
      chk("i_req_lat1", {31'b0, s_req}, 32'd1);
      chk("i_we", {31'b0, s_we}, 32'd0);
      wait_done("i_read_done");
      use_fixed = 1'b0;

      // Stray ack while idle.
      force_ack = 1'b1;
      cycle();
      chk("stray_ok", {30'b0, s_i_ok, s_d_ok}, 32'd0);
      chk("stray_busy0", {31'b0, s_busy}, 32'd0);
      force_ack = 1'b0;
      cycle();
      chk("stray_busy1", {31'b0, s_busy}, 32'd0);

      // Watchdog abort, then re-grant to I.
      mem_auto = 1'b0;
      i_addr = 32'h0040_0200;
      exp_req(1'b0, 32'h0040_0200, 32'h0, 8, -1); exp_rsp(2, 32'h0);
      exp_req(1'b0, 32'h0040_0200, 32'h0, 2, 1);  exp_rsp(0, 32'hFFBF_FDFF);
      i_read_req = 1'b1;
      repeat (9) cycle();
      chk("to_busy_last", {31'b0, s_busy}, 32'd1);
      cycle();
      chk("to_idle", {31'b0, s_busy}, 32'd0);
      chk("to_err", {31'b0, s_to}, 32'd1);
      mem_auto = 1'b1; ack_delay = 2;
      wait_done("to_regrant_done");

      // Ack in the watchdog's final cycle wins.
      ack_delay = 8;
      i_addr = 32'h0040_0300;
      exp_req(1'b0, 32'h0040_0300, 32'h0, 8, -1); exp_rsp(0, 32'hFFBF_FCFF);
      i_read_req = 1'b1;
      wait_done("to_edge_done");

      // D write, then D read+write together (still a write).
      ack_delay = 3;
      d_addr = 32'h0000_1000; d_wdata = 32'h1234_5678;
      exp_req(1'b1, 32'h0000_1000, 32'h1234_5678, 3, -1); exp_rsp(1, 32'hFFFF_EFFF);
      d_write_req = 1'b1;
      cycle();
      cycle();
      chk("d_we", {31'b0, s_we}, 32'd1);
      wait_done("d_write_done");
      d_addr = 32'h0000_2000; d_wdata = 32'h0BAD_F00D;
      exp_req(1'b1, 32'h0000_2000, 32'h0BAD_F00D, 3, -1); exp_rsp(1, 32'hFFFF_DFFF);
      d_write_req = 1'b1; d_read_req = 1'b1;
      wait_done("d_rw_done");

      // Reset in the middle of a D write; a late ack must be ignored.
      mem_auto = 1'b0;
      d_addr = 32'h0000_5000; d_wdata = 32'h7777_8888;
      exp_req(1'b1, 32'h0000_5000, 32'h7777_8888, 3, -1);
      d_write_req = 1'b1;
      repeat (3) cycle();
      rst = 1'b1; d_write_req = 1'b0;
      cycle();
      chk("rst_was_busy", {31'b0, s_busy}, 32'd1);
      rst = 1'b0; force_ack = 1'b1;
      cycle();
      chk("rst_all_zero", {31'b0, s_zero}, 32'd1);
      chk("rst_no_dok", {31'b0, s_d_ok}, 32'd0);
      force_ack = 1'b0;
      cycle();
      chk("rst_idle", {31'b0, s_busy}, 32'd0);

      // Contention after reset must go to D first again.
      mem_auto = 1'b1; ack_delay = 2; d_wdata = '0;
      d_addr = 32'h0000_4000; i_addr = 32'h0040_0400;
      exp_req(1'b0, 32'h0000_4000, 32'h0, 2, -1); exp_rsp(1, 32'hFFFF_BFFF);
      exp_req(1'b0, 32'h0040_0400, 32'h0, 2, 1);  exp_rsp(0, 32'hFFBF_FBFF);
      i_read_req = 1'b1; d_read_req = 1'b1;
      wait_done("contend3_done");

      repeat (3) cycle();
      chk("req_q_empty", 32'(req_q.size()), 32'd0);
      chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
